// File: rtl/idli_fetch_ctrl_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_fetch_ctrl_m
// Purpose  : Instruction fetch sequencer. Issues the SQI read transaction
//            (command, address, dummy turnaround) to external memory and
//            streams instruction nibbles to the 4b/cycle decoder. Tracks the
//            fetch PC, holds the SQI clock on backend stall and restarts the
//            stream on a redirect or on PC wrap-around.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_fch_gck         clock
//   i_fch_rst         asynchronous active-high reset
//   i_fch_stall       backend cannot accept a nibble this cycle
//   i_fch_redir       redirect request (branch/jump taken)
//   i_fch_redir_pc    redirect target word address [15:0]
//   i_sqi_din         SQI data from memory [3:0]
//   o_sqi_cs_n        SQI chip select, active-low
//   o_sqi_sck_en      SQI clock enable (memory advances when 1)
//   o_sqi_dout        SQI data to memory [3:0]
//   o_sqi_oe          drive o_sqi_dout onto the pads
//   o_fch_enc         nibble to decoder [3:0]
//   o_fch_enc_vld     nibble valid to decoder
//   o_fch_flush       1-cycle pulse: decoder drops its partial instruction
//   o_fch_pc          word address of the instruction being delivered [15:0]
//   o_fch_bubble_cnt  saturating bubble-cycle counter [15:0]
//                     (present only when IDLI_FETCH_PERF_EN is defined)
// Configuration macro: IDLI_FETCH_PERF_EN
// ============================================================================
module idli_fetch_ctrl_m #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [7:0]  READ_CMD     = 8'hEB,
    parameter int          ADDR_NIBBLES = 6,
    parameter int          DUMMY_CYCLES = 2
) (
    input  logic        i_fch_gck,
    input  logic        i_fch_rst,
    input  logic        i_fch_stall,
    input  logic        i_fch_redir,
    input  logic [15:0] i_fch_redir_pc,
    input  logic [3:0]  i_sqi_din,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_dout,
    output logic        o_sqi_oe,
    output logic [3:0]  o_fch_enc,
    output logic        o_fch_enc_vld,
    output logic        o_fch_flush,
    output logic [15:0] o_fch_pc
`ifdef IDLI_FETCH_PERF_EN
    ,
    output logic [15:0] o_fch_bubble_cnt
`endif
);

    localparam int         c_CNT_W    = 8;
    localparam int         c_ADDR_W   = 4 * ADDR_NIBBLES;

    localparam logic [2:0] c_ST_DESEL = 3'd0;
    localparam logic [2:0] c_ST_CMD   = 3'd1;
    localparam logic [2:0] c_ST_ADDR  = 3'd2;
    localparam logic [2:0] c_ST_DUMMY = 3'd3;
    localparam logic [2:0] c_ST_DATA  = 3'd4;

    logic [2:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [15:0]         r_pc;
    logic [1:0]          r_nib;

    logic [2:0]          w_state_nxt;
    logic                w_vld;
    logic                w_wrap;
    logic [c_ADDR_W-1:0] w_addr;
    logic [3:0]          w_addr_nib;

    // A nibble is consumed only in DATA when neither stalled nor redirected;
    // the same condition gates the SQI clock so memory never runs ahead.
    assign w_vld  = (r_state == c_ST_DATA) && !i_fch_stall && !i_fch_redir;

    // Completing the instruction at the top of the address space restarts the
    // transaction at 0 rather than letting the memory stream past the end.
    assign w_wrap = w_vld && (r_nib == 2'd3) && (r_pc == 16'hFFFF);

    // Byte address = word address * 2, zero-extended to the address field.
    assign w_addr = c_ADDR_W'({r_pc, 1'b0});

    // Address nibble for the current ADDR cycle, most significant first.
    always_comb begin
        w_addr_nib = 4'h0;
        for (int i = 0; i < ADDR_NIBBLES; i++) begin
            if (r_cnt == c_CNT_W'(ADDR_NIBBLES - 1 - i)) begin
                w_addr_nib = w_addr[4*i +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register plus PC / nibble / phase counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_fch_gck or posedge i_fch_rst) begin
        if (i_fch_rst) begin
            r_state <= c_ST_DESEL;
            r_cnt   <= '0;
            r_pc    <= RESET_PC;
            r_nib   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (i_fch_redir || (w_state_nxt != r_state)) begin
                r_cnt <= '0;
            end else if (r_state != c_ST_DATA) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (i_fch_redir) begin
                r_pc  <= i_fch_redir_pc;
                r_nib <= 2'd0;
            end else if (w_vld) begin
                r_nib <= r_nib + 2'd1;
                if (r_nib == 2'd3) begin
                    r_pc <= r_pc + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_DESEL: w_state_nxt = c_ST_CMD;
            c_ST_CMD: begin
                if (r_cnt == c_CNT_W'(1)) w_state_nxt = c_ST_ADDR;
            end
            c_ST_ADDR: begin
                if (r_cnt == c_CNT_W'(ADDR_NIBBLES - 1)) w_state_nxt = c_ST_DUMMY;
            end
            c_ST_DUMMY: begin
                if (r_cnt == c_CNT_W'(DUMMY_CYCLES - 1)) w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_wrap) w_state_nxt = c_ST_DESEL;
            end
            default: w_state_nxt = c_ST_DESEL;
        endcase
        // Redirect overrides everything, including a pending wrap.
        if (i_fch_redir) begin
            w_state_nxt = c_ST_DESEL;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        o_sqi_cs_n    = 1'b1;
        o_sqi_sck_en  = 1'b0;
        o_sqi_dout    = 4'h0;
        o_sqi_oe      = 1'b0;
        o_fch_enc     = 4'h0;
        o_fch_enc_vld = 1'b0;
        o_fch_flush   = 1'b0;
        case (r_state)
            c_ST_CMD: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_oe     = 1'b1;
                o_sqi_sck_en = 1'b1;
                o_sqi_dout   = (r_cnt == '0) ? READ_CMD[7:4] : READ_CMD[3:0];
            end
            c_ST_ADDR: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_oe     = 1'b1;
                o_sqi_sck_en = 1'b1;
                o_sqi_dout   = w_addr_nib;
            end
            c_ST_DUMMY: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sck_en = 1'b1;
            end
            c_ST_DATA: begin
                o_sqi_cs_n    = 1'b0;
                o_sqi_sck_en  = w_vld;
                o_fch_enc     = i_sqi_din;
                o_fch_enc_vld = w_vld;
                // Only a partially delivered instruction needs dropping.
                o_fch_flush   = i_fch_redir && (r_nib != 2'd0);
            end
            default: ;
        endcase
    end

    assign o_fch_pc = r_pc;

`ifdef IDLI_FETCH_PERF_EN
    logic [15:0] r_bubble_cnt;
    logic        w_bubble;

    assign w_bubble = (r_state != c_ST_DATA) || i_fch_stall;

    always_ff @(posedge i_fch_gck or posedge i_fch_rst) begin
        if (i_fch_rst) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign o_fch_bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
